// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//   Brightness and PWM stage placed after the 8-LED chaser. A lit pattern bit
//   drives its LED to full brightness. Once the bit clears, the LED fades out
//   in fixed steps on every decay tick, so the moving dot leaves a trail.
//
// Ports
//   CLK         system clock
//   RST         asynchronous active-high reset
//   pattern_in  chaser pattern; bit i high forces LED i to full brightness
//   freeze      suppresses decay while high (pattern bits still force MAX)
//   led_n       active-low registered PWM drive, one bit per LED
//   decay_tick  one-cycle registered strobe, every DECAY_DIV cycles
module led_trail_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 46875,
  parameter int DECAY_STEP = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] pattern_in,
  input  logic       freeze,
  output logic [7:0] led_n,
  output logic       decay_tick
);

  localparam int PRE_W = $clog2(DECAY_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q [8];
  logic [PWM_BITS-1:0] level_d [8];
  logic [PWM_BITS-1:0] duty_q  [8];
  logic [PWM_BITS-1:0] duty_d  [8];
  logic [7:0]          led_n_q, led_n_d;

  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d    = (pre_cnt_q == PRE_LAST);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    led_n_d   = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      if (pattern_in[i]) begin
        level_d[i] = LVL_MAX;
      end else if (tick_q && !freeze) begin
        // Saturating subtract: a level at or below the step goes straight to 0.
        level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
      end
      // Duty is only reloaded at the end of a PWM period so a level change
      // never shortens or stretches the on-phase already in progress.
      duty_d[i]  = (pwm_cnt_q == LVL_MAX) ? level_q[i] : duty_q[i];
      led_n_d[i] = !(pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      led_n_q   <= 8'hFF;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_n_q   <= led_n_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign led_n      = led_n_q;
  assign decay_tick = tick_q;

endmodule
